// File: rtl/systolic_seq_ctrl_if.sv
// Bundle for the sequencer: the sample handshake, the multiplier launch/busy
// pair and the PE adder strobes. master = environment side, slave = sequencer.
interface systolic_seq_ctrl_if #(
   parameter int WORDLENGTH = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic [WORDLENGTH-1:0] inputword;
   logic [2:0]            start_index;
   logic [WORDLENGTH-1:0] mult_a;
   logic [2:0]            coeff_sel;
   logic                  mult_start;
   logic                  mult_busy;
   logic                  acc_en;
   logic                  acc_clear;
   logic [2:0]            word_index;
   logic                  frame_done;
   logic                  timeout_err;

   modport master (
      output in_valid, inputword, start_index, mult_busy,
      input  in_ready, mult_a, coeff_sel, mult_start, acc_en, acc_clear,
             word_index, frame_done, timeout_err
   );

   modport slave (
      input  in_valid, inputword, start_index, mult_busy,
      output in_ready, mult_a, coeff_sel, mult_start, acc_en, acc_clear,
             word_index, frame_done, timeout_err
   );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for one systolic interpolation row: accepts a sample, launches the
// shared multiplier, waits on its busy flag and strobes the PE accumulator.
module systolic_seq_ctrl #(
   parameter int WORDLENGTH   = 16,
   parameter int MULT_TIMEOUT = 64
) (
   input logic               clk30x,
   input logic               reset,
   systolic_seq_ctrl_if.slave bus
);

   localparam int CNT_W = $clog2(MULT_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      ARM    = 3'd2,
      RUN    = 3'd3,
      ACCUM  = 3'd4
   } state_t;

   state_t                state_r, state_s;
   logic [CNT_W-1:0]      cnt_r, cnt_s, cnt_inc_s;
   logic                  accept_s, timeout_s;
   logic [WORDLENGTH-1:0] mult_a_r;
   logic [2:0]            word_index_r, start_q_r;
   logic                  frame_start_r, timeout_err_r;
   logic                  in_ready_r, mult_start_r, acc_en_r, acc_clear_r, frame_done_r;

   // Next-state decode; the busy counter only advances while RUN sees busy.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      accept_s  = 1'b0;
      timeout_s = 1'b0;
      cnt_inc_s = cnt_r + CNT_W'(1);
      case (state_r)
         IDLE: begin
            if (bus.in_valid && in_ready_r) begin
               accept_s = 1'b1;
               state_s  = LAUNCH;
            end else begin
               state_s  = IDLE;
            end
         end
         LAUNCH: state_s = ARM;
         ARM: begin
            state_s = RUN;
            cnt_s   = '0;
         end
         RUN: begin
            if (!bus.mult_busy) begin
               state_s = ACCUM;
            end else if (cnt_inc_s == CNT_W'(MULT_TIMEOUT)) begin
               timeout_s = 1'b1;
               state_s   = IDLE;
               cnt_s     = cnt_inc_s;
            end else begin
               cnt_s     = cnt_inc_s;
            end
         end
         ACCUM:   state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State and busy-cycle counter.
   always_ff @(posedge clk30x or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
         cnt_r   <= '0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end
   end

   // Strobes are registered from the next state so they line up with it.
   always_ff @(posedge clk30x or negedge reset) begin
      if (!reset) begin
         in_ready_r   <= 1'b1;
         mult_start_r <= 1'b0;
         acc_en_r     <= 1'b0;
         acc_clear_r  <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         in_ready_r   <= (state_s == IDLE);
         mult_start_r <= (state_s == LAUNCH);
         acc_en_r     <= (state_s == ACCUM);
         acc_clear_r  <= (state_s == ACCUM) && (word_index_r == start_q_r);
         frame_done_r <= (state_s == ACCUM) && (word_index_r == start_q_r + 3'd7);
      end
   end

   // Sample latch, tap position and frame bookkeeping.
   always_ff @(posedge clk30x or negedge reset) begin
      if (!reset) begin
         mult_a_r      <= '0;
         word_index_r  <= 3'd0;
         start_q_r     <= 3'd0;
         frame_start_r <= 1'b1;
         timeout_err_r <= 1'b0;
      end else begin
         if (timeout_s) begin
            timeout_err_r <= 1'b1;
         end
         if (accept_s) begin
            mult_a_r      <= bus.inputword;
            frame_start_r <= 1'b0;
            // A new frame restarts the tap walk at the row's start position.
            if (frame_start_r) begin
               start_q_r    <= bus.start_index;
               word_index_r <= bus.start_index;
            end
         end
         if (acc_en_r) begin
            word_index_r <= word_index_r + 3'd1;
            if (frame_done_r) begin
               frame_start_r <= 1'b1;
            end
         end
      end
   end

   assign bus.in_ready    = in_ready_r;
   assign bus.mult_a      = mult_a_r;
   assign bus.coeff_sel   = word_index_r - start_q_r;
   assign bus.mult_start  = mult_start_r;
   assign bus.acc_en      = acc_en_r;
   assign bus.acc_clear   = acc_clear_r;
   assign bus.word_index  = word_index_r;
   assign bus.frame_done  = frame_done_r;
   assign bus.timeout_err = timeout_err_r;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Scoreboard bench: the driver pushes the expected outcome of each sample from
// a frame/tap-position model; a monitor checks each transaction as it retires.
module tb_systolic_seq_ctrl;
   localparam int WL = 16;
   localparam int TO = 64;

   logic clk30x = 1'b0;
   logic reset  = 1'b1;
   always #5 clk30x = ~clk30x;

   systolic_seq_ctrl_if #(.WORDLENGTH(WL)) bus ();

   systolic_seq_ctrl #(.WORDLENGTH(WL), .MULT_TIMEOUT(TO)) dut (
      .clk30x(clk30x),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [15:0] a;
      logic [2:0]  coeff;
      logic        clr;
      logic        done;
      logic [2:0]  wi_after;
      logic        tmo;
      logic        err;
      int          len;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   passes = 0;

   // Reference model: position of the next tap inside the current frame.
   int         m_pos  = 0;
   bit         m_open = 1'b0;
   int         m_base = 0;
   bit         m_err  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk30x);
      #1;
   endtask

   task automatic send(input logic [15:0] d, input logic [2:0] si, input int len);
      exp_t e;
      int   n;
      n = 0;
      tick();
      bus.in_valid    = 1'b1;
      bus.inputword   = d;
      bus.start_index = si;
      while (!bus.in_ready && n < 200) begin
         tick();
         n++;
      end
      if (!bus.in_ready) begin
         chk("ready_wait", 32'(bus.in_ready), 32'd1);
         bus.in_valid = 1'b0;
         return;
      end
      if (!m_open) begin
         m_open = 1'b1;
         m_base = int'(si);
         m_pos  = 0;
      end
      e.a     = d;
      e.coeff = 3'(m_pos);
      e.clr   = (m_pos == 0);
      e.done  = (m_pos == 7);
      e.tmo   = (len >= TO);
      e.len   = len;
      if (e.tmo) begin
         m_err = 1'b1;
      end else begin
         m_pos++;
         if (m_pos == 8) begin
            m_pos  = 0;
            m_open = 1'b0;
         end
      end
      e.err      = m_err;
      e.wi_after = 3'((m_base + m_pos) % 8);
      sb_q.push_back(e);
      tick();
      bus.in_valid = 1'b0;
      tick();
      bus.mult_busy = (len > 0);
      if (len > 0) begin
         repeat (len + 1) tick();
         bus.mult_busy = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      chk("drain", 32'(sb_q.size()), 32'd0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"},    32'(bus.in_ready),    32'd1);
      chk({tag, "_mult_a"},      32'(bus.mult_a),      32'd0);
      chk({tag, "_word_index"},  32'(bus.word_index),  32'd0);
      chk({tag, "_coeff_sel"},   32'(bus.coeff_sel),   32'd0);
      chk({tag, "_mult_start"},  32'(bus.mult_start),  32'd0);
      chk({tag, "_acc_en"},      32'(bus.acc_en),      32'd0);
      chk({tag, "_acc_clear"},   32'(bus.acc_clear),   32'd0);
      chk({tag, "_frame_done"},  32'(bus.frame_done),  32'd0);
      chk({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
   endtask

   // Monitor: record launch/accumulate events, retire a transaction when in_ready rises.
   int          cyc = 0, acc_cyc = 0, ms_cyc = 0, ae_cyc = 0, ms_n = 0, ae_n = 0, stray = 0;
   logic        prev_ready = 1'b1;
   logic [15:0] ms_a;
   logic [2:0]  ms_coeff, ae_coeff;
   logic        ae_clr, ae_done;

   always @(negedge clk30x) begin
      exp_t e;
      cyc++;
      if (!reset) begin
         prev_ready = 1'b1;
         ms_n = 0;
         ae_n = 0;
      end else begin
         if (bus.in_ready && !prev_ready) begin
            if (sb_q.size() == 0) begin
               chk("sb_nonempty", 32'(sb_q.size()), 32'd1);
            end else begin
               e = sb_q.pop_front();
               chk("mult_start_count", 32'(ms_n), 32'd1);
               chk("mult_start_lat", 32'(ms_cyc - acc_cyc), 32'd1);
               chk("mult_a", 32'(ms_a), 32'(e.a));
               chk("coeff_sel_launch", 32'(ms_coeff), 32'(e.coeff));
               chk("timeout_err", 32'(bus.timeout_err), 32'(e.err));
               chk("word_index", 32'(bus.word_index), 32'(e.wi_after));
               if (e.tmo) begin
                  chk("acc_en_count_tmo", 32'(ae_n), 32'd0);
                  chk("ready_lat_tmo", 32'(cyc - acc_cyc), 32'(3 + TO));
               end else begin
                  chk("acc_en_count", 32'(ae_n), 32'd1);
                  chk("acc_lat", 32'(ae_cyc - acc_cyc), 32'(4 + e.len));
                  chk("ready_lat", 32'(cyc - acc_cyc), 32'(5 + e.len));
                  chk("acc_clear", 32'(ae_clr), 32'(e.clr));
                  chk("frame_done", 32'(ae_done), 32'(e.done));
                  chk("coeff_sel_accum", 32'(ae_coeff), 32'(e.coeff));
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            acc_cyc = cyc;
            ms_n = 0;
            ae_n = 0;
         end
         if (bus.mult_start) begin
            ms_n++;
            ms_cyc   = cyc;
            ms_a     = bus.mult_a;
            ms_coeff = bus.coeff_sel;
         end
         if (bus.acc_en) begin
            ae_n++;
            ae_cyc   = cyc;
            ae_clr   = bus.acc_clear;
            ae_done  = bus.frame_done;
            ae_coeff = bus.coeff_sel;
         end
         if (!bus.acc_en && (bus.acc_clear || bus.frame_done)) stray++;
         prev_ready = bus.in_ready;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid    = 1'b0;
      bus.inputword   = '0;
      bus.start_index = 3'd0;
      bus.mult_busy   = 1'b0;
      #1 reset = 1'b0;
      repeat (3) @(negedge clk30x);
      chk_reset_vals("por");
      @(negedge clk30x);
      reset = 1'b1;

      // Single sample with three busy cycles, then close the frame back-to-back.
      send(16'h1234, 3'd0, 3);
      for (int i = 0; i < 7; i++) send(16'(i + 1), 3'd0, 0);
      // Fresh frame starting at tap 5.
      for (int i = 0; i < 8; i++) send(16'($urandom), 3'd5, 0);
      // start_index changes mid-frame are ignored until the frame completes.
      send(16'hA5A5, 3'd2, 1);
      for (int i = 0; i < 7; i++) send(16'($urandom), 3'd6, $urandom_range(0, 2));
      for (int i = 0; i < 3; i++) send(16'($urandom), 3'd6, 0);
      // Stuck busy, then a normal sample; the error flag stays set.
      send(16'hDEAD, 3'd1, 70);
      send(16'hBEEF, 3'd1, 2);
      drain();

      // Reset while RUN is waiting on busy.
      tick();
      bus.in_valid    = 1'b1;
      bus.inputword   = 16'h7777;
      bus.start_index = 3'd3;
      while (!bus.in_ready) tick();
      tick();
      bus.in_valid = 1'b0;
      tick();
      bus.mult_busy = 1'b1;
      tick();
      tick();
      #2 reset = 1'b0;
      #1 chk_reset_vals("run_rst");
      bus.mult_busy = 1'b0;
      m_pos  = 0;
      m_open = 1'b0;
      m_base = 0;
      m_err  = 1'b0;
      @(negedge clk30x);
      #2 reset = 1'b1;
      send(16'h0F0F, 3'd4, 1);

      // Randomized traffic with occasional timeouts.
      for (int i = 0; i < 60; i++) begin
         send(16'($urandom), 3'($urandom_range(0, 7)),
              ($urandom_range(0, 19) == 0) ? 70 : int'($urandom_range(0, 5)));
      end
      drain();
      chk("stray_strobes", 32'(stray), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/systolic_seq_ctrl.md
# systolic_seq_ctrl

Sequencer for one systolic interpolation row. Accepts non-uniform samples over a valid/ready handshake and launches the shared sequential multiplier once per sample. It tracks multiplier completion through its busy flag rather than a fixed count, then issues accumulate/clear strobes to the PE adder. It sits between the sample source and the PE multiplier/multALU pair, replacing the PE's free-running count-to-`timing` loop.

## Interface
Parameters:
- `WORDLENGTH`, 16, sample/coefficient word width
- `MULT_TIMEOUT`, 64, max cycles `mult_busy` may stay high before abort (≥4)

Ports:
- `clk30x`  in  1  single clock, all logic rising-edge
- `reset`  in  1  asynchronous, active-low; all state cleared immediately on assertion
- `in_valid`  in  1  sample offered
- `in_ready`  out  1  controller can accept sample
- `inputword`  in  WORDLENGTH  sample value
- `start_index`  in  3  row's starting tap position (the PE's startIndex)
- `mult_a`  out  WORDLENGTH  latched sample to multiplier
- `coeff_sel`  out  3  C_row entry to present on multiplier B
- `mult_start`  out  1  one-cycle multiplier launch pulse
- `mult_busy`  in  1  multiplier busy flag
- `acc_en`  out  1  one-cycle strobe: register adder output as previous output
- `acc_clear`  out  1  with `acc_en`: previous-output operand forced to 0
- `word_index`  out  3  current tap index
- `frame_done`  out  1  one-cycle pulse: eighth tap of a row accumulated
- `timeout_err`  out  1  sticky multiplier-timeout flag

## Operation
- States: IDLE, LAUNCH, ARM, RUN, ACCUM.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`: latch `inputword`→`mult_a`, go LAUNCH. If `frame_start` is set, also capture `start_index`→`start_q`.
- `frame_start` is an internal flag: set on reset and after each `frame_done`, cleared on accept.
- LAUNCH: `mult_start`=1 for exactly this cycle, go ARM.
- ARM: `mult_busy` ignored (multiplier raises busy one cycle after start), go RUN; clear timeout counter.
- RUN: if `mult_busy`=0 go ACCUM, else increment counter. When the counter reaches MULT_TIMEOUT: set `timeout_err`, go IDLE, leave `word_index` unchanged, and issue no `acc_en`; the sample is dropped.
- ACCUM: `acc_en`=1, `acc_clear`=(`word_index`==`start_q`), `word_index`←`word_index`+1 (mod 8, wraps 7→0).
  - `frame_done`=1 if `word_index`==(`start_q`+7) mod 8.
  - Go IDLE.
- `coeff_sel` = (`word_index` − `start_q`) mod 8, 3-bit unsigned wrap. Combinational from registers; stable from LAUNCH through ACCUM.
- `start_index` changes are ignored mid-frame; they take effect only at the next frame start.
- `timeout_err` clears only on reset. Operation continues normally after a timeout.

## Timing
- Reset values: state IDLE, `in_ready`=1, `mult_a`=0, `word_index`=0, `start_q`=0, `frame_start`=1. `mult_start`, `acc_en`, `acc_clear`, `frame_done`, `timeout_err` all 0.
- Accept at cycle T → `mult_start` at T+1 → ARM at T+2 → first RUN at T+3.
- With busy low in RUN at cycle R, ACCUM (`acc_en`) occurs at R+1 and `in_ready` returns to 1 at R+2.
- Minimum accept-to-accept: 5 cycles (busy never observed high).
- `in_ready` is a decode of registered state, so it has no combinational path from `in_valid`.
- `in_valid` held while `in_ready`=0 is not consumed. The source must hold `inputword` until acceptance.
- `word_index` updates on the edge ending ACCUM. `frame_done` and `acc_en` are coincident.
- Reset asserted in any state: outputs return to reset values asynchronously, and any in-flight sample is lost.

## Test plan
- Reset then one sample 0x1234, `start_index`=0, busy high 3 cycles after ARM:
  - `mult_start` at T+1.
  - `acc_en`+`acc_clear` at T+7.
  - `mult_a`=0x1234, `coeff_sel`=0.
  - `word_index`=1 afterwards.
- `start_index`=5, 8 back-to-back samples:
  - `coeff_sel` sequence 0..7 (`word_index` runs 5,6,7,0,…,4).
  - `acc_clear` only on the first sample.
  - `frame_done` only on the 8th, `word_index`=5 afterwards.
- Busy never asserted: accepts occur every 5 cycles, `in_ready` low for 4 cycles each time.
- Busy stuck high: `timeout_err`=1 after 64 RUN cycles, no `acc_en`, `word_index` unchanged. The next sample completes normally and `timeout_err` stays 1.
- Change `start_index` 2→6 mid-frame: `coeff_sel` continues from `start_q`=2, and 6 is used only after `frame_done`.
- Assert reset during RUN: all outputs at reset values within the same cycle, `in_ready`=1. After release, the first sample uses `acc_clear`=1 and `coeff_sel`=0.
